// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester (IF/DM) and memory-side signal bundle for mem_port_arbiter
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    logic        arb_err;

    // Arbiter side: serves the two requesters and drives the memory.
    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
        output if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata, arb_err
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata, arb_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - DM-priority IF/DM arbiter for one single-ported memory with IF anti-starvation
// Optional mem_ready timeout with sticky arb_err is enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT   = 2,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic             Clk,
    input  logic             Rst,
    mem_port_arbiter_if.slave bus
);

    localparam int            SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    if (STARVE_LIMIT < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mem_port_arbiter: STARVE_LIMIT and TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   dm_rdata_q, dm_rdata_d;
    logic          if_ack_q, if_ack_d;
    logic          dm_ack_q, dm_ack_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          fin;
    logic [31:0]   fin_data;
    logic          dm_wins;

`ifdef ARB_TIMEOUT_EN
    localparam int            WW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] TO_LAST = WW'(TIMEOUT_CYCLES - 1);

    logic [WW-1:0] wait_q, wait_d;
    logic          arb_err_q, arb_err_d;
`endif

    // IF is forced only once DM has won STARVE_LIMIT times in a row while IF waited.
    assign dm_wins = bus.dm_req && !(bus.if_req && (starve_q == STARVE_MAX));

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        starve_d    = starve_q;
        fin         = 1'b0;
        fin_data    = bus.mem_rdata;
`ifdef ARB_TIMEOUT_EN
        wait_d      = wait_q;
        arb_err_d   = arb_err_q;
`endif

        case (state_q)
            IDLE: begin
                if (dm_wins) begin
                    state_d     = BUSY_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.dm_we;
                    mem_addr_d  = bus.dm_addr;
                    mem_wdata_d = bus.dm_wdata;
                    if (bus.if_req) begin
                        starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
                    end else begin
                        starve_d = '0;
                    end
`ifdef ARB_TIMEOUT_EN
                    wait_d      = '0;
`endif
                end else if (bus.if_req) begin
                    state_d     = BUSY_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                    mem_wdata_d = '0;
                    starve_d    = '0;
`ifdef ARB_TIMEOUT_EN
                    wait_d      = '0;
`endif
                end
            end

            BUSY_IF, BUSY_DM: begin
                if (bus.mem_ready) begin
                    fin = 1'b1;
                end
`ifdef ARB_TIMEOUT_EN
                else if (wait_q == TO_LAST) begin
                    fin       = 1'b1;
                    fin_data  = 32'hDEADBEEF;
                    arb_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`endif
                if (fin) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (state_q == BUSY_DM) begin
                        dm_rdata_d = fin_data;
                        dm_ack_d   = 1'b1;
                    end else begin
                        if_rdata_d = fin_data;
                        if_ack_d   = 1'b1;
                    end
                end
            end

            // The ack cycle: requesters drop req here, so IDLE never re-grants a finished access.
            DONE: state_d = IDLE;

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            starve_q    <= '0;
`ifdef ARB_TIMEOUT_EN
            wait_q      <= '0;
            arb_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            starve_q    <= starve_d;
`ifdef ARB_TIMEOUT_EN
            wait_q      <= wait_d;
            arb_err_q   <= arb_err_d;
`endif
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.dm_ack    = dm_ack_q;
`ifdef ARB_TIMEOUT_EN
    assign bus.arb_err   = arb_err_q;
`else
    assign bus.arb_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int LIMIT = 2;
    localparam int TO    = 4;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    logic        mem_ready_s = 1'b0;
    logic [31:0] mem_rdata_s = 32'h0;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .TIMEOUT_CYCLES(TO)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    assign bus.mem_ready = mem_ready_s;
    assign bus.mem_rdata = mem_rdata_s;

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Simple memory: answers after mem_waits not-ready cycles of a request.
    int          mem_waits = 0;
    logic [31:0] mem_data  = 32'h0;
    int          mcnt      = 0;

    always @(posedge Clk) begin
        #1;
        if (bus.mem_req) begin
            if (mcnt >= mem_waits) begin
                mem_ready_s = 1'b1;
                mem_rdata_s = mem_data;
            end else begin
                mem_ready_s = 1'b0;
                mcnt++;
            end
        end else begin
            mem_ready_s = 1'b0;
            mcnt = 0;
        end
    end

    // Transaction-level model: one memory slot, an owed ack, and a DM win streak.
    bit          m_busy  = 1'b0;
    bit          m_dm    = 1'b0;
    bit          m_we    = 1'b0;
    bit          m_err   = 1'b0;
    int          m_ack   = 0;
    int          m_streak = 0;
    int          m_waits = 0;
    logic [31:0] m_addr     = 32'h0;
    logic [31:0] m_wdata    = 32'h0;
    logic [31:0] m_if_rdata = 32'h0;
    logic [31:0] m_dm_rdata = 32'h0;
    byte         m_log[$];
    byte         dut_log[$];

    task automatic m_complete(input logic [31:0] data);
        m_busy = 1'b0;
        m_ack  = m_dm ? 2 : 1;
        if (m_dm) m_dm_rdata = data;
        else      m_if_rdata = data;
    endtask

    always @(posedge Clk) begin
        if (Rst) begin
            m_busy = 0; m_dm = 0; m_we = 0; m_err = 0; m_ack = 0; m_streak = 0; m_waits = 0;
            m_addr = 0; m_wdata = 0; m_if_rdata = 0; m_dm_rdata = 0;
        end else if (m_ack != 0) begin
            m_ack = 0;
        end else if (m_busy) begin
            if (bus.mem_ready) begin
                m_complete(bus.mem_rdata);
            end else begin
                m_waits++;
`ifdef ARB_TIMEOUT_EN
                if (m_waits == TO) begin
                    m_complete(32'hDEADBEEF);
                    m_err = 1'b1;
                end
`endif
            end
        end else if (bus.dm_req && !(bus.if_req && m_streak >= LIMIT)) begin
            m_busy = 1; m_dm = 1; m_we = bus.dm_we; m_waits = 0;
            m_addr = bus.dm_addr; m_wdata = bus.dm_wdata;
            m_streak = bus.if_req ? ((m_streak < LIMIT) ? m_streak + 1 : LIMIT) : 0;
            m_log.push_back("D");
        end else if (bus.if_req) begin
            m_busy = 1; m_dm = 0; m_we = 0; m_waits = 0;
            m_addr = bus.if_addr;
            m_streak = 0;
            m_log.push_back("I");
        end
    end

    always @(negedge Clk) begin
        chk1("mem_req", bus.mem_req, m_busy);
        chk1("mem_we", bus.mem_we, m_busy && m_we);
        if (m_busy) begin
            chk32("mem_addr", bus.mem_addr, m_addr);
            if (m_dm) chk32("mem_wdata", bus.mem_wdata, m_wdata);
        end
        chk1("if_ack", bus.if_ack, m_ack == 1);
        chk1("dm_ack", bus.dm_ack, m_ack == 2);
        if (m_ack == 1) chk32("if_rdata", bus.if_rdata, m_if_rdata);
        if (m_ack == 2 && !m_we) chk32("dm_rdata", bus.dm_rdata, m_dm_rdata);
        chk1("arb_err", bus.arb_err, m_err);
        chk1("ack_exclusive", bus.if_ack && bus.dm_ack, 1'b0);
        if (bus.if_ack) dut_log.push_back("I");
        if (bus.dm_ack) dut_log.push_back("D");
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        int  hold;
        int  n;
        bit  got;
        bit  we_seen;
        int  acks[3];
        byte exp_order[6];

        exp_order = '{"D", "D", "I", "D", "D", "I"};
        bus.if_req = 0; bus.if_addr = 0;
        bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = 0; bus.dm_wdata = 0;

        step(); step();
        chk1 ("rst_mem_req",   bus.mem_req,   1'b0);
        chk1 ("rst_mem_we",    bus.mem_we,    1'b0);
        chk32("rst_mem_addr",  bus.mem_addr,  32'h0);
        chk32("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk32("rst_if_rdata",  bus.if_rdata,  32'h0);
        chk32("rst_dm_rdata",  bus.dm_rdata,  32'h0);
        chk1 ("rst_acks",      bus.if_ack || bus.dm_ack, 1'b0);
        chk1 ("rst_arb_err",   bus.arb_err,   1'b0);
        Rst = 0;

        // Reset in the middle of a DM access.
        mem_waits = 1000;
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h80;
        step(); step();
        chk1("t1_busy_mem_req", bus.mem_req, 1'b1);
        Rst = 1;
        step();
        chk1("t1_rst_mem_req", bus.mem_req, 1'b0);
        chk1("t1_rst_dm_ack",  bus.dm_ack,  1'b0);
        Rst = 0; bus.dm_req = 0; mem_waits = 0;
        step(); step();
        chk1("t1_no_late_ack", bus.dm_ack, 1'b0);

        // IF read, zero-wait memory.
        mem_data = 32'h2002000A; mem_waits = 0;
        bus.if_req = 1; bus.if_addr = 32'h100;
        cyc = 1; we_seen = 0;
        for (int i = 0; i < 10; i++) begin
            we_seen |= bus.mem_we;
            step(); cyc++;
            we_seen |= bus.mem_we;
            if (bus.if_ack) break;
        end
        chk32("t2_ack_cycle", cyc, 3);
        chk32("t2_if_rdata", bus.if_rdata, 32'h2002000A);
        chk1 ("t2_mem_we_low", we_seen, 1'b0);
        step(); bus.if_req = 0;

        // DM write with two wait cycles; later requester changes must be ignored.
        mem_waits = 2; mem_data = 32'hCAFE0000;
        bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h40; bus.dm_wdata = 32'h55;
        cyc = 1; hold = 0;
        for (int i = 0; i < 12; i++) begin
            step(); cyc++;
            if (bus.mem_req && bus.mem_we && bus.mem_addr == 32'h40 && bus.mem_wdata == 32'h55) hold++;
            if (cyc == 2) begin bus.dm_addr = 32'h99; bus.dm_wdata = 32'h77; end
            if (bus.dm_ack) break;
        end
        chk32("t3_hold_cycles", hold, 3);
        chk32("t3_ack_cycle", cyc, 5);
        step(); bus.dm_req = 0; bus.dm_we = 0;

        // DM alone, back-to-back.
        mem_waits = 0; mem_data = 32'h11110000;
        bus.dm_req = 1; bus.dm_addr = 32'h200;
        cyc = 1; n = 0; got = 0;
        for (int i = 0; i < 20; i++) begin
            step(); cyc++;
            if (bus.if_ack) got = 1;
            if (bus.dm_ack && n < 3) begin acks[n] = cyc; n++; end
            if (n == 3) break;
        end
        step(); bus.dm_req = 0;
        chk32("t5_first_ack", acks[0], 3);
        chk32("t5_spacing_1", acks[1] - acks[0], 3);
        chk32("t5_spacing_2", acks[2] - acks[1], 3);
        chk1 ("t5_no_if_ack", got, 1'b0);
        step();

        // Both held continuously: anti-starvation order.
        dut_log.delete(); m_log.delete();
        mem_data = 32'h0BADF00D;
        bus.if_req = 1; bus.if_addr = 32'h300;
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h400;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.if_ack || bus.dm_ack) n++;
            if (n == 6) break;
        end
        step(); bus.if_req = 0; bus.dm_req = 0;
        for (int i = 0; i < 6; i++) begin
            chk32($sformatf("t4_dut_grant%0d", i), (dut_log.size() > i) ? 32'(dut_log[i]) : 32'h0, 32'(exp_order[i]));
            chk32($sformatf("t4_model_grant%0d", i), (m_log.size() > i) ? 32'(m_log[i]) : 32'h0, 32'(exp_order[i]));
        end
        step(); step();

        // mem_ready stuck low on an IF access.
        mem_waits = 1000;
        bus.if_req = 1; bus.if_addr = 32'h500;
`ifdef ARB_TIMEOUT_EN
        cyc = 1;
        for (int i = 0; i < 20; i++) begin
            step(); cyc++;
            if (bus.if_ack) break;
        end
        chk32("t6_ack_cycle", cyc, TO + 2);
        chk32("t6_if_rdata", bus.if_rdata, 32'hDEADBEEF);
        chk1 ("t6_arb_err", bus.arb_err, 1'b1);
        step(); bus.if_req = 0; mem_waits = 0;
        step(); step();
        chk1("t6_arb_err_sticky", bus.arb_err, 1'b1);
        Rst = 1;
        step();
        chk1("t6_arb_err_cleared", bus.arb_err, 1'b0);
        Rst = 0;
`else
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.if_ack) n++;
        end
        chk32("t6_no_ack", n, 0);
        chk1 ("t6_still_waiting", bus.mem_req, 1'b1);
        chk1 ("t6_arb_err_zero", bus.arb_err, 1'b0);
        Rst = 1;
        step();
        Rst = 0; bus.if_req = 0; mem_waits = 0;
        chk1("t6_abandoned", bus.mem_req, 1'b0);
`endif
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
